uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Parametrised, buffered UART transmitter with a valid/ready input and an internal transmit FIFO. It serialises words LSB-first with a start bit, optional odd/even parity and one or two stop bits. Baud rate is set at run time by an integer clock divisor. It replaces the fixed-rate, unbuffered transmit path: software or an upstream engine streams words in, and frames go out back-to-back with no idle gap.

## Interface
Parameters:
- DATA_W, 9: maximum data bits per frame; legal range 5..9.
- FIFO_DEPTH, 8: number of FIFO entries; must be a power of two, at least 2.
- DIV_W, 16: width of the baud divisor.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- tx_valid  in  1  upstream word valid.
- tx_ready  out  1  FIFO can accept a word; equals (fifo_count < FIFO_DEPTH).
- tx_data  in  DATA_W  word to send; bit 0 is sent first.
- data_length  in  4  data bits per frame; values below 5 clamp to 5, values above DATA_W clamp to DATA_W.
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none.
- stop_bits  in  1  0 gives one stop bit, 1 gives two.
- baud_div  in  DIV_W  bit period minus one, in clk cycles; 0 is legal and gives a 1-cycle bit.
- serial_data_out  out  1  line output; idle is high.
- busy  out  1  high while a frame is on the line.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

## Operation
- A word is pushed on any rising edge where tx_valid and tx_ready are both high. Upstream must hold tx_data stable while tx_valid is high and tx_ready is low.
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE: if the FIFO is not empty, pop the head entry and go to START. On the pop, latch the word, the clamped data_length, parity_type, stop_bits and baud_div. Changing any config input mid-frame has no effect on the current frame.
- START: drive 0 for one bit period, then go to DATA.
- DATA: drive latched bits 0..len-1, one per bit period. Bits at or above len are ignored. Then go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: the bit is the XOR of the len data bits for even parity, and its inverse for odd parity.
- STOP: drive 1 for one or two bit periods. At the end of the last stop period:
  - if the FIFO is not empty, pop and go directly to START, with no idle cycle;
  - otherwise go to IDLE.
- Bit-period counter: loads the latched divisor at the start of every bit and decrements to 0. The bit advances on the cycle after the counter reads 0, so each bit lasts exactly baud_div+1 cycles.
- FIFO: a simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH. A push is impossible when full because tx_ready is low. A pop never occurs when empty.
- busy is low only in IDLE.

## Timing
- Reset values: serial_data_out=1, busy=0, fifo_count=0, tx_ready=1, FSM in IDLE, bit counter at 0.
- Reset mid-frame: the line returns high asynchronously and the FIFO is flushed. No partial frame resumes after reset is released.
- Latency: if a word is pushed at edge k into an empty FIFO while IDLE, it is visible at edge k, popped at edge k+1, and serial_data_out goes low from edge k+1.
- tx_ready and fifo_count update on the edge after a push or pop.
- Frame length in cycles is (1 + len + P + S) × (baud_div+1), where P is 0 or 1 and S is 1 or 2.
- serial_data_out is driven directly from a flop; there is no combinational path from any input to it.

## Structure
- Package uart_pkg holds:
  - parity_e, with PAR_NONE, PAR_ODD, PAR_EVEN and PAR_NONE2;
  - tx_state_e;
  - function clamp_len(len, max), shared with the receiver.
- Sub-module uart_fifo: a synchronous, parametrised FIFO with WIDTH and DEPTH parameters, push/pop/full/empty/count signals, and the asynchronous active-low reset.
- The top level contains the FSM, the bit-period counter, the bit index and the shift register.

## Test plan
- Single frame: baud_div=3, data 0xA5, len=8, even parity, 1 stop.
  - Required line sequence: 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles, 44 cycles total.
  - busy goes 1 to 0 exactly after the frame.
- Odd parity with 2 stop bits, len=7, data 0x7F, baud_div=0.
  - Required line sequence: 0, then 1×7, then parity 0, then 1, 1; 11 cycles total.
- Clamping: data_length=2 with data 0x1F.
  - Required: 5 data bits sent, all 1.
  - Repeat with data_length=15 and DATA_W=9: 9 data bits sent.
- Back-to-back and full FIFO: push 9 words with FIFO_DEPTH=8 while the line is busy.
  - tx_ready must drop at fifo_count=8.
  - Frames are contiguous: the last stop bit is followed immediately by a start bit.
  - All 9 words arrive in order.
- Config change mid-frame: switch baud_div from 3 to 7 during DATA.
  - The current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
- Reset mid-frame: assert resetn=0 during DATA with 3 words queued.
  - serial_data_out=1 immediately and fifo_count=0.
  - After release the line stays idle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   parity_e   : parity_type encoding (00 none, 01 odd, 10 even, 11 none)
//   tx_state_e : transmit FSM states
//   clamp_len  : limits a requested data length to MIN_LEN..max
package uart_pkg;

  localparam int unsigned MIN_LEN = 5;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE2 = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max);
    if (len < 4'(MIN_LEN)) return 4'(MIN_LEN);
    if (len > max) return max;
    return len;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
//   clk, resetn : clock, asynchronous active-low reset (flushes pointers/count)
//   push_i      : write wdata_i (ignored when full)
//   pop_i       : drop head entry (ignored when empty)
//   rdata_o     : head entry
//   full_o, empty_o, count_o : occupancy status
module uart_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, optional parity, 1/2 stop bits,
// run-time baud divisor. Frames are sent back-to-back while the FIFO has data.
//   clk, resetn      : clock, asynchronous active-low reset
//   tx_valid/ready   : upstream handshake, tx_data is the pushed word
//   data_length      : data bits per frame (clamped to 5..DATA_W)
//   parity_type      : 00/11 none, 01 odd, 10 even
//   stop_bits        : 0 one stop bit, 1 two
//   baud_div         : bit period minus one, in clk cycles
//   serial_data_out  : registered line output, idle high
//   busy             : frame in progress
//   fifo_count       : FIFO occupancy
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic [3:0]                    data_length,
  input  logic [1:0]                    parity_type,
  input  logic                          stop_bits,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          serial_data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q;
  logic [3:0]        bit_idx_q, bit_idx_d, len_q, len_in;
  logic [DATA_W-1:0] shreg_q, shreg_d, fifo_rdata;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q, tx_d;
  logic              par_en_q, par_bit_q, stop2_q;
  logic              par_en_in, par_bit_in, par_xor;
  logic              fifo_full, fifo_empty, pop;
  logic              advance, last_data, last_stop;
  parity_e           par_type;

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (tx_valid),
    .pop_i   (pop),
    .wdata_i (tx_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_ready        = !fifo_full;
  assign busy            = (state_q != IDLE);
  assign serial_data_out = tx_q;

  // Frame configuration sampled from the inputs at the moment of a pop.
  always_comb begin
    len_in   = clamp_len(data_length, 4'(DATA_W));
    par_type = parity_e'(parity_type);
    par_xor  = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < 32'(len_in)) par_xor = par_xor ^ fifo_rdata[i];
    end
    par_en_in  = (par_type == PAR_ODD) || (par_type == PAR_EVEN);
    par_bit_in = (par_type == PAR_ODD) ? ~par_xor : par_xor;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    advance   = (cnt_q == '0);
    last_data = (bit_idx_q == len_q - 4'd1);
    last_stop = !stop2_q || stop_idx_q;
    state_d   = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (advance) state_d = DATA;
      DATA:    if (advance && last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (advance) state_d = STOP;
      STOP:    if (advance && last_stop) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values. A pop is any entry into START, which
  // covers both the IDLE launch and the back-to-back launch from STOP.
  always_comb begin
    pop     = (state_d == START) && (state_q != START);
    shreg_d = shreg_q;
    if (pop)                            shreg_d = fifo_rdata;
    else if (state_q == DATA && advance) shreg_d = shreg_q >> 1;

    if (state_d == IDLE) cnt_d = '0;
    else if (pop)        cnt_d = baud_div;
    else if (advance)    cnt_d = div_q;
    else                 cnt_d = cnt_q - DIV_W'(1);

    bit_idx_d  = (state_q == DATA) ? (advance ? bit_idx_q + 4'd1 : bit_idx_q) : '0;
    stop_idx_d = (state_q == STOP) ? (advance ? 1'b1 : stop_idx_q) : 1'b0;

    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_q       <= 1'b1;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      len_q      <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      tx_q       <= tx_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      if (pop) begin
        len_q     <= len_in;
        div_q     <= baud_div;
        par_en_q  <= par_en_in;
        par_bit_q <= par_bit_in;
        stop2_q   <= stop_bits;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tx_valid;
  logic        tx_ready;
  logic [8:0]  tx_data;
  logic [3:0]  data_length;
  logic [1:0]  parity_type;
  logic        stop_bits;
  logic [15:0] baud_div;
  logic        serial_data_out;
  logic        busy;
  logic [3:0]  fifo_count;

  typedef struct {
    logic [8:0] data;
    int         len;
    int         par;   // 0 none, 1 odd, 2 even
    bit         stop2;
    int         div;
    bit         b2b;   // must start right after the previous frame's last stop cycle
  } exp_t;

  exp_t scb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   frames_rx = 0;
  int   mcyc = 0;
  int   last_end = 0;

  uart_tx_buffered #(
    .DATA_W     (9),
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data),
    .data_length     (data_length),
    .parity_type     (parity_type),
    .stop_bits       (stop_bits),
    .baud_div        (baud_div),
    .serial_data_out (serial_data_out),
    .busy            (busy),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int dv, input int len, input int par, input bit st2);
    baud_div    = 16'(dv);
    data_length = 4'(len);
    parity_type = 2'(par);
    stop_bits   = st2;
  endtask

  // Drives one word through the handshake; the expected frame is queued with
  // the configuration the bench expects the DUT to latch when it pops it.
  task automatic push(input logic [8:0] d, input int len, input int par,
                      input bit st2, input int dv, input bit b2b);
    exp_t e;
    int   w;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    w = 0;
    while (tx_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) chk("push_ready_timeout", 32'(w), 32'd0);
    e.data = d; e.len = len; e.par = par; e.stop2 = st2; e.div = dv; e.b2b = b2b;
    scb.push_back(e);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Called right after a push into an empty, idle DUT.
  task automatic frame_cycles(input string tag, input int exp_n);
    int w, n;
    w = 0;
    @(negedge clk);
    while (busy !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start_latency"}, 32'(w), 32'd1);
    chk({tag, "_start_low"}, 32'(serial_data_out), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_idle_high"}, 32'(serial_data_out), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int w;
    w = 0;
    while ((scb.size() != 0 || busy !== 1'b0) && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (w >= budget) chk({tag, "_drain_timeout"}, 32'(w), 32'(budget - 1));
    repeat (3) @(negedge clk);
  endtask

  // Line monitor: decodes every frame against the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    logic exp_bits [0:15];
    int   nb, ones;
    bit   aborted;
    forever begin
      @(negedge clk);
      mcyc++;
      if (resetn === 1'b1 && serial_data_out === 1'b0) begin
        if (scb.size() == 0) begin
          chk("unexpected_start", 32'(scb.size()), 32'd1);
          for (int k = 0; k < 1000 && serial_data_out === 1'b0; k++) begin
            @(negedge clk);
            mcyc++;
          end
        end else begin
          e = scb.pop_front();
          if (e.b2b) chk($sformatf("frame%0d_b2b_gap", frames_rx), 32'(mcyc - last_end), 32'd1);
          nb = 0;
          exp_bits[nb] = 1'b0; nb++;
          ones = 0;
          for (int i = 0; i < e.len; i++) begin
            exp_bits[nb] = e.data[i]; nb++;
            if (e.data[i]) ones++;
          end
          if (e.par == 1) begin exp_bits[nb] = (ones % 2 == 0); nb++; end
          else if (e.par == 2) begin exp_bits[nb] = (ones % 2 == 1); nb++; end
          exp_bits[nb] = 1'b1; nb++;
          if (e.stop2) begin exp_bits[nb] = 1'b1; nb++; end
          aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            for (int c = 0; c <= e.div && !aborted; c++) begin
              if (b != 0 || c != 0) begin
                @(negedge clk);
                mcyc++;
                if (resetn !== 1'b1) aborted = 1'b1;
                else chk($sformatf("frame%0d_bit%0d_cyc%0d", frames_rx, b, c),
                         32'(serial_data_out), 32'(exp_bits[b]));
              end
            end
          end
          if (!aborted) begin
            frames_rx++;
            last_end = mcyc;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, frames %0d", frames_rx);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int lows;
    resetn   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    cfg(3, 8, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_line", 32'(serial_data_out), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_ready", 32'(tx_ready), 32'd1);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame: 0xA5, 8 bits, even parity, one stop, 4-cycle bits
    cfg(3, 8, 2, 0);
    push(9'h0A5, 8, 2, 0, 3, 0);
    chk("t1_count_after_push", 32'(fifo_count), 32'd1);
    chk("t1_line_still_idle", 32'(serial_data_out), 32'd1);
    frame_cycles("t1", 44);
    chk("t1_count_empty", 32'(fifo_count), 32'd0);
    repeat (3) @(negedge clk);

    // Odd parity, two stops, 7 bits, 1-cycle bits
    cfg(0, 7, 1, 1);
    push(9'h07F, 7, 1, 1, 0, 0);
    frame_cycles("t2", 11);
    repeat (3) @(negedge clk);

    // Length clamping at both ends
    cfg(0, 2, 0, 0);
    push(9'h01F, 5, 0, 0, 0, 0);
    frame_cycles("clamp_low", 7);
    repeat (3) @(negedge clk);
    cfg(0, 15, 3, 0);
    push(9'h155, 9, 0, 0, 0, 0);
    frame_cycles("clamp_high", 11);
    repeat (3) @(negedge clk);

    // Nine words back-to-back fill the FIFO
    cfg(1, 8, 0, 0);
    for (int i = 0; i < 9; i++) begin
      push(9'(i * 29 + 3), 8, 0, 0, 1, (i != 0));
      if (i == 7) begin
        chk("b2b_count_7", 32'(fifo_count), 32'd7);
        chk("b2b_ready_at_7", 32'(tx_ready), 32'd1);
      end
    end
    chk("b2b_count_full", 32'(fifo_count), 32'd8);
    chk("b2b_ready_full", 32'(tx_ready), 32'd0);
    drain("b2b", 1000);
    chk("b2b_frames_total", 32'(frames_rx), 32'd13);
    chk("b2b_ready_after", 32'(tx_ready), 32'd1);

    // Divisor change mid-frame affects only the following frame
    cfg(3, 8, 0, 0);
    push(9'h03C, 8, 0, 0, 3, 0);
    push(9'h0C3, 8, 0, 0, 7, 1);
    repeat (8) @(negedge clk);
    chk("cfg_busy_at_change", 32'(busy), 32'd1);
    baud_div = 16'd7;
    drain("cfg", 1000);
    chk("cfg_frames_total", 32'(frames_rx), 32'd15);

    // Reset during DATA with three words still queued
    cfg(3, 8, 0, 0);
    push(9'h0F0, 8, 0, 0, 3, 0);
    push(9'h00F, 8, 0, 0, 3, 1);
    push(9'h0AA, 8, 0, 0, 3, 1);
    push(9'h055, 8, 0, 0, 3, 1);
    chk("rst_queued", 32'(fifo_count), 32'd3);
    repeat (6) @(negedge clk);
    chk("rst_busy_before", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_line_high", 32'(serial_data_out), 32'd1);
    chk("rst_count_flushed", 32'(fifo_count), 32'd0);
    chk("rst_busy_low", 32'(busy), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    scb.delete();
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (serial_data_out !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("rst_stays_idle", 32'(lows), 32'd0);
    chk("rst_count_after", 32'(fifo_count), 32'd0);

    chk("final_scoreboard_empty", 32'(scb.size()), 32'd0);
    chk("final_frames", 32'(frames_rx), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
